// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite responder backed by a word-organised memory.
// Latency: zero-wait data phase by default. WAIT_STATES extra stall cycles are
// added to every OKAY beat. An illegal access gets a two-cycle ERROR response.
// Backpressure: HREADYOUT is driven low during wait cycles and the first
// ERROR cycle. A new address phase is taken only while HREADYOUT=1.
//
// Ports:
//   HCLK, HRESETn      clock and synchronous active-low reset
//   HSEL, HADDR[7:0]   select and byte address (address phase)
//   HTRANS, HWRITE     transfer type and direction (address phase)
//   HSIZE, HBURST      access size and burst type (HBURST is not decoded)
//   HWDATA[31:0]       write data (data phase)
//   HREADY             bus-level ready; gates acceptance of the address phase
//   HRDATA[31:0]       read data, valid in the read data-phase cycle
//   HREADYOUT, HRESP   slave ready and response (0 OKAY, 1 ERROR)

module ahb_lite_mem_slave #(
  parameter int MEM_WORDS   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [7:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [8:0] MEM_BYTES = 9'(MEM_WORDS * 4);
  localparam logic [2:0] WS        = 3'(WAIT_STATES);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]  state;
  logic [2:0]  wait_cnt;
  logic [7:0]  addr_q;
  logic        write_q;
  logic [2:0]  size_q;

  logic [31:0] mem [MEM_WORDS];

  logic             accept;
  logic             addr_err;
  logic             commit;
  logic [3:0]       wr_mask;
  logic [IDX_W-1:0] word_idx;
  logic             unused_bits;

  // Byte lanes touched by an access, little-endian.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
    case (size)
      3'd0:    lane_mask = 4'b0001 << ofs;
      3'd1:    lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Gated by our own HREADYOUT as well, so a stray HREADY during a stall
  // cannot overwrite the registered address of the beat in progress.
  assign accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  // Out-of-range addresses are rejected outright so they can never alias
  // onto a lower word through the truncated index.
  assign addr_err = (HSIZE > 3'd2) ||
                    ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                    ({1'b0, HADDR} >= MEM_BYTES);

  assign word_idx = addr_q[IDX_W+1:2];
  assign wr_mask  = lane_mask(size_q, addr_q[1:0]);
  assign commit   = (state == ST_DATA) && write_q;

  assign unused_bits = ^{HBURST, HTRANS[0], addr_q};

  // Outputs depend only on registered state, keeping HREADYOUT free of
  // combinational paths from the bus inputs.
  always_comb begin
    HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    HRDATA    = '0;
    if ((state == ST_DATA) && !write_q) begin
      HRDATA = mem[word_idx];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else if (accept) begin
      addr_q   <= HADDR;
      write_q  <= HWRITE;
      size_q   <= HSIZE;
      wait_cnt <= WS;
      if (addr_err) begin
        state <= ST_ERR1;
      end else if (WS == 3'd0) begin
        state <= ST_DATA;
      end else begin
        state <= ST_WAIT;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= ST_DATA;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes land on the edge that ends the data phase, so a read issued
  // back-to-back to the same word already sees the new value.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
module tb_ahb_lite_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        hsel_g;
  int          inst;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_kill;
  logic        chk_en;

  logic [1:0]  hsel_i;
  logic [1:0]  hready_i;
  logic [31:0] hrdata_o [2];
  logic [1:0]  hreadyout_o;
  logic [1:0]  hresp_o;

  int total = 0;
  int bad   = 0;

  // Instance 0 has no wait states, instance 1 has two.
  assign hsel_i[0]   = hsel_g && (inst == 0);
  assign hsel_i[1]   = hsel_g && (inst == 1);
  assign hready_i[0] = hreadyout_o[0] && !hready_kill;
  assign hready_i[1] = hreadyout_o[1] && !hready_kill;

  ahb_lite_mem_slave #(.MEM_WORDS(32), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel_i[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready_i[0]),
    .HRDATA(hrdata_o[0]), .HREADYOUT(hreadyout_o[0]), .HRESP(hresp_o[0]));

  ahb_lite_mem_slave #(.MEM_WORDS(32), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel_i[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready_i[1]),
    .HRDATA(hrdata_o[1]), .HREADYOUT(hreadyout_o[1]), .HRESP(hresp_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slave holds at most one beat in its data phase; cyc counts how many
  // cycles that beat has been in the data phase so far.
  typedef struct {
    bit         vld;
    bit         err;
    bit         wr;
    logic [7:0] addr;
    logic [2:0] size;
    int         cyc;
  } ph_t;

  ph_t         ph [2];
  logic [31:0] mm [2][32];
  int          ws [2] = '{0, 2};

  function automatic bit legal(input logic [7:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if (int'(a) >= 128) return 1'b0;
    if (s == 3'd1 && (a % 2) != 0) return 1'b0;
    if (s == 3'd2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_rdy(input int k);
    if (!ph[k].vld) return 1'b1;
    if (ph[k].err) return ph[k].cyc == 1;
    return ph[k].cyc == ws[k];
  endfunction

  function automatic bit exp_resp(input int k);
    return ph[k].vld && ph[k].err;
  endfunction

  function automatic logic [31:0] exp_data(input int k);
    if (ph[k].vld && !ph[k].err && !ph[k].wr && ph[k].cyc == ws[k])
      return mm[k][ph[k].addr / 4];
    return 32'h0;
  endfunction

  task automatic model_step();
    bit rdy;
    int lane;
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        ph[k].vld = 1'b0;
        for (int w = 0; w < 32; w++) mm[k][w] = 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy = exp_rdy(k);
        if (ph[k].vld && rdy) begin
          if (!ph[k].err && ph[k].wr) begin
            for (int b = 0; b < (1 << ph[k].size); b++) begin
              lane = int'(ph[k].addr % 4) + b;
              mm[k][ph[k].addr / 4][8*lane +: 8] = hwdata[8*lane +: 8];
            end
          end
          ph[k].vld = 1'b0;
        end else if (ph[k].vld) begin
          ph[k].cyc++;
        end
        if (rdy && hsel_i[k] && hready_i[k] && htrans[1])
          ph[k] = '{1'b1, !legal(haddr, hsize), hwrite, haddr, hsize, 0};
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("hreadyout[%0d]", k), 32'(hreadyout_o[k]), 32'(exp_rdy(k)));
        chk($sformatf("hresp[%0d]", k), 32'(hresp_o[k]), 32'(exp_resp(k)));
        chk($sformatf("hrdata[%0d]", k), hrdata_o[k], exp_data(k));
      end
    end
  end

  // ---------------- bus driver ----------------
  typedef struct {
    logic [7:0]  a;
    bit          w;
    logic [2:0]  s;
    logic [1:0]  t;
    logic [31:0] d;
  } beat_t;

  beat_t       bq [$];
  logic [31:0] rd_r [16];
  logic        rs_r [16];
  int          st_r [16];

  task automatic add(input logic [7:0] a, input bit w, input logic [2:0] s,
                     input logic [1:0] t, input logic [31:0] d);
    beat_t b;
    b = '{a, w, s, t, d};
    bq.push_back(b);
  endtask

  task automatic put_addr(input beat_t b);
    hsel_g = 1'b1; haddr = b.a; hwrite = b.w; hsize = b.s; htrans = b.t;
  endtask

  task automatic go_idle();
    hsel_g = 1'b0; haddr = 8'h0; hwrite = 1'b0; hsize = 3'd0; htrans = 2'b00;
  endtask

  // Issues the queued beats back-to-back (pipelined) to slave k; records
  // read data, response and stall count per beat. Starts and ends 1 after posedge.
  task automatic run(input int k);
    int n;
    int stalls;
    n = bq.size();
    inst = k;
    put_addr(bq[0]);
    for (int i = 0; i <= n; i++) begin
      stalls = 0;
      @(negedge clk);
      while (!hreadyout_o[k] && stalls < 20) begin
        stalls++;
        @(negedge clk);
      end
      if (stalls >= 20) chk("hreadyout_timeout", 32'(stalls), 32'd0);
      if (i > 0) begin
        rd_r[i-1] = hrdata_o[k];
        rs_r[i-1] = hresp_o[k];
        st_r[i-1] = stalls;
      end
      @(posedge clk); #1;
      hwdata = (i < n) ? bq[i].d : 32'h0;
      if (i + 1 < n) put_addr(bq[i+1]);
      else go_idle();
    end
    bq.delete();
  endtask

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; go_idle(); hwdata = 32'h0; hburst = 3'd0; hready_kill = 1'b0;
    inst = 0; chk_en = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hreadyout", 32'(hreadyout_o[0]), 32'd1);
    chk("reset_hresp", 32'(hresp_o[1]), 32'd0);
    chk("reset_hrdata", hrdata_o[0], 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Word write then read, no wait states.
    add(8'h04, 1, 3'd2, NS, 32'hDEADBEEF); run(0);
    add(8'h04, 0, 3'd2, NS, 32'h0); run(0);
    chk("word_read", rd_r[0], 32'hDEADBEEF);
    chk("word_read_resp", 32'(rs_r[0]), 32'd0);
    chk("word_read_stalls", 32'(st_r[0]), 32'd0);

    // Byte lanes, then back-to-back read of the same word.
    add(8'h08, 1, 3'd0, NS, 32'h11111111);
    add(8'h09, 1, 3'd0, NS, 32'h22222222);
    add(8'h0A, 1, 3'd0, NS, 32'h33333333);
    add(8'h0B, 1, 3'd0, NS, 32'h44444444);
    add(8'h08, 0, 3'd2, NS, 32'h0);
    run(0);
    chk("byte_read", rd_r[4], 32'h44332211);
    chk("model_byte_word", mm[0][2], 32'h44332211);
    add(8'h0A, 1, 3'd1, NS, 32'hABCDABCD);
    add(8'h08, 0, 3'd2, NS, 32'h0);
    run(0);
    chk("half_read", rd_r[1], 32'hABCD2211);

    // Illegal accesses: ERROR for two cycles, memory untouched.
    add(8'h00, 1, 3'd2, NS, 32'h12345678);
    add(8'h02, 1, 3'd2, NS, 32'hFFFFFFFF);
    add(8'h01, 1, 3'd1, NS, 32'hFFFFFFFF);
    add(8'h80, 1, 3'd2, NS, 32'hFFFFFFFF);
    add(8'h00, 1, 3'd3, NS, 32'hFFFFFFFF);
    add(8'h00, 0, 3'd2, NS, 32'h0);
    run(0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("err_resp_%0d", i), 32'(rs_r[i]), 32'd1);
      chk($sformatf("err_stalls_%0d", i), 32'(st_r[i]), 32'd1);
    end
    chk("err_mem_unchanged", rd_r[5], 32'h12345678);
    chk("err_read_resp_ok", 32'(rs_r[5]), 32'd0);

    // Non-accesses: HSEL=0, BUSY, HREADY=0.
    inst = 0; hsel_g = 1'b0; htrans = NS; hwrite = 1'b1; haddr = 8'h00; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'hFFFFFFFF; hsel_g = 1'b1; htrans = 2'b01;
    @(posedge clk); #1;
    htrans = NS; hready_kill = 1'b1;
    @(posedge clk); #1;
    hready_kill = 1'b0; go_idle();
    @(posedge clk); #1;
    add(8'h00, 0, 3'd2, NS, 32'h0); run(0);
    chk("noaccess_mem_unchanged", rd_r[0], 32'h12345678);

    // Two wait states: SEQ write burst, single read, SEQ read burst.
    for (int i = 0; i < 4; i++)
      add(8'(8'h10 + 4*i), 1, 3'd2, (i == 0) ? NS : SQ, 32'hA0000000 + 32'(i));
    run(1);
    for (int i = 0; i < 4; i++) chk($sformatf("ws_wr_stalls_%0d", i), 32'(st_r[i]), 32'd2);
    add(8'h10, 0, 3'd2, NS, 32'h0); run(1);
    chk("ws_read", rd_r[0], 32'hA0000000);
    chk("ws_read_stalls", 32'(st_r[0]), 32'd2);
    for (int i = 0; i < 4; i++)
      add(8'(8'h10 + 4*i), 0, 3'd2, (i == 0) ? NS : SQ, 32'h0);
    run(1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_burst_data_%0d", i), rd_r[i], 32'hA0000000 + 32'(i));
      chk($sformatf("ws_burst_stalls_%0d", i), 32'(st_r[i]), 32'd2);
    end

    // Reset in a wait cycle of a write: aborted, memory cleared.
    inst = 1; hsel_g = 1'b1; haddr = 8'h20; hwrite = 1'b1; hsize = 3'd2; htrans = NS;
    @(posedge clk); #1;
    hwdata = 32'hCAFEF00D; go_idle(); rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_hreadyout", 32'(hreadyout_o[1]), 32'd1);
    chk("midrst_hresp", 32'(hresp_o[1]), 32'd0);
    chk("midrst_hrdata", hrdata_o[1], 32'h0);
    @(posedge clk); #1;
    add(8'h20, 0, 3'd2, NS, 32'h0); run(1);
    chk("midrst_read_0x20", rd_r[0], 32'h0);
    add(8'h04, 0, 3'd2, NS, 32'h0); run(0);
    chk("midrst_cleared_0x04", rd_r[0], 32'h0);

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite responder: a word-addressed memory behind the 8-bit-address, 32-bit-data AHB-Lite bus that the project's AHB master drives.
- Provides the slave end of the bus, and later becomes the register front-end of the AHB-to-SPI bridge.
- Supports byte/halfword/word accesses, configurable wait states, and ERROR responses for illegal accesses.

Parameters:
- MEM_WORDS, 32: number of 32-bit words; legal byte addresses 0 .. MEM_WORDS*4-1 (max 64).
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase (0..7).

Ports:
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESETn  in  1  synchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  8  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBURST  in  3  accepted, not decoded (addresses taken from HADDR each beat).
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus-level ready; address phase sampled only when 1.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (HRESETn=0 at an edge):
  - HREADYOUT=1, HRESP=0, HRDATA=0; FSM to IDLE; wait counter=0; all memory words cleared to 0.
  - Reset mid-transfer aborts it; a pending write is not committed.
- Address phase:
  - A transfer is accepted at an edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ.
  - Registers addr_q, write_q, size_q.
  - HTRANS IDLE/BUSY, or HSEL=0, accepts nothing; next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Error check at accept:
  - Error if HSIZE>2, or halfword with HADDR[0]=1, or word with HADDR[1:0]!=0, or HADDR>=MEM_WORDS*4.
  - Error → ERR1 regardless of WAIT_STATES.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accept OKAY → WAIT_STATES==0 ? DATA : WAIT (counter=WAIT_STATES). Accept error → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0, counter decrements each cycle; counter==1 → DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes at the end of this cycle. A new transfer may be accepted in the same cycle (pipelined) with the same next-state rules; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; accept rules as in DATA, else → IDLE. No memory access occurs for an errored transfer.
- Write commit at the DATA-exit edge:
  - Byte lane n (HWDATA[8n+7:8n]) is written to byte n of mem[addr_q[7:2]] for the lanes selected by size_q/addr_q[1:0]. Little-endian; other bytes unchanged.
- Read data:
  - In DATA with write_q=0, HRDATA = full word mem[addr_q[7:2]] (all lanes; master extracts); HRDATA=0 in all other cycles.
  - Combinational from registered address, so zero-wait reads are valid in the first data-phase cycle.
- Hazards:
  - Write data phase followed back-to-back by a read of the same word: the write commits at the edge that ends the write's data phase, so the read returns the new data.
  - WAIT_STATES>0 applies to every OKAY beat, including pipelined SEQ beats.
- Width: internal word index is addr_q[7:2]. Out-of-range addresses never alias.

Test Plan:
- Reset, WAIT_STATES=0: write word 0xDEADBEEF to 0x04, then read 0x04 → HRDATA=0xDEADBEEF in the data-phase cycle, HREADYOUT=1 throughout, HRESP=0.
- Byte writes 0x11,0x22,0x33,0x44 to 0x08,0x09,0x0A,0x0B, then word read 0x08 → 0x44332211. Halfword write 0xABCD to 0x0A, then read → 0xABCD2211.
- WAIT_STATES=2: NONSEQ read at 0x10 → HREADYOUT low exactly 2 cycles, then high with HRDATA=mem[4]. Four-beat SEQ burst 0x10..0x1C → each beat 2 waits, correct data.
- Errors: word access to 0x02, halfword access to 0x01, access to 0x80 (MEM_WORDS=32), HSIZE=3 → each gives HREADYOUT 0 then 1 with HRESP=1 for both cycles; memory unchanged on readback.
- HSEL=0 with HTRANS=NONSEQ, HTRANS=BUSY, and HREADY=0 with valid transfer → no access, HREADYOUT stays 1, memory unchanged.
- Assert HRESETn=0 during a WAIT cycle of a write to 0x20 → outputs at reset values next cycle; read 0x20 after reset → 0x00000000.
